// File: rtl/pio_ctrl.sv
// pio_ctrl: memory-mapped parallel-output peripheral with set/clear/toggle
// writes, registered read-back and an optional per-bit LED blink engine.
// All state updates on the falling edge of clk; rst is synchronous, active-high.
// Optional feature macro: PIO_BLINK_EN (blink engine, BLINK and PERIOD registers).
// Without it, addresses 4 and 5 behave like 6 and 7.
// Assumes LED_W <= DW and PRESC_W <= DW.
module pio_ctrl #(
  parameter int unsigned DW             = 32,
  parameter int unsigned LED_W          = 8,
  parameter bit          LED_ACTIVE_LOW = 1'b1,
  parameter int unsigned PRESC_W        = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic             WE,
  input  logic [2:0]       ADDR,
  input  logic [DW-1:0]    PData_in,
  output logic [DW-1:0]    PData_out,
  output logic             rd_valid,
  output logic [LED_W-1:0] LED,
  output logic [DW-1:0]    GPIOf0
);

  logic wr, rd;
  assign wr = EN & WE;
  assign rd = EN & ~WE;

  logic [DW-1:0] gpio_q, gpio_d;
  logic [DW-1:0] pdata_q, pdata_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data;

  // Blink-side values seen by the read mux and LED logic; constant zero when
  // the blink engine is not built.
  logic [LED_W-1:0]   blink_val;
  logic [PRESC_W-1:0] period_val;
  logic               phase_val;

`ifdef PIO_BLINK_EN
  logic [LED_W-1:0]   blink_q, blink_d;
  logic [PRESC_W-1:0] period_q, period_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic               phase_q, phase_d;

  // Blink registers and prescaler; a PERIOD write beats the terminal count.
  always_comb begin
    blink_d  = blink_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    if (wr && ADDR == 3'd4) blink_d = PData_in[LED_W-1:0];
    if (wr && ADDR == 3'd5) begin
      period_d = PData_in[PRESC_W-1:0];
      cnt_d    = '0;
    end else if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == period_q) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + PRESC_W'(1);
    end
  end

  // Blink state flops.
  always_ff @(negedge clk) begin
    if (rst) begin
      blink_q  <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
    end else begin
      blink_q  <= blink_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  assign blink_val  = blink_q;
  assign period_val = period_q;
  assign phase_val  = phase_q;
`else
  assign blink_val  = '0;
  assign period_val = '0;
  assign phase_val  = 1'b0;
`endif

  // Output register write modes.
  always_comb begin
    gpio_d = gpio_q;
    if (wr) begin
      case (ADDR)
        3'd0:    gpio_d = PData_in;
        3'd1:    gpio_d = gpio_q | PData_in;
        3'd2:    gpio_d = gpio_q & ~PData_in;
        3'd3:    gpio_d = gpio_q ^ PData_in;
        default: gpio_d = gpio_q;
      endcase
    end
  end

  // Read mux; unimplemented addresses return zero.
  always_comb begin
    rd_data = '0;
    case (ADDR)
      3'd0, 3'd1, 3'd2, 3'd3: rd_data = gpio_q;
      3'd4:                   rd_data[LED_W-1:0] = blink_val;
      3'd5:                   rd_data[PRESC_W-1:0] = period_val;
      default:                rd_data = '0;
    endcase
  end

  // Read data holds between reads; rd_valid pulses for one cycle per read.
  always_comb begin
    pdata_d    = rd ? rd_data : pdata_q;
    rd_valid_d = rd;
  end

  // Core register flops.
  always_ff @(negedge clk) begin
    if (rst) begin
      gpio_q     <= '0;
      pdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      gpio_q     <= gpio_d;
      pdata_q    <= pdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // LED pins: blink-masked low bits of the output register, then polarity.
  always_comb begin
    logic [LED_W-1:0] raw;
    raw = gpio_q[LED_W-1:0] ^ (blink_val & {LED_W{phase_val}});
    LED = LED_ACTIVE_LOW ? ~raw : raw;
  end

  assign GPIOf0    = gpio_q;
  assign PData_out = pdata_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_pio_ctrl.sv
// Bench for pio_ctrl: directed vector table, hand-written blink sequences and a
// randomized run against a behavioural model. Works with or without PIO_BLINK_EN.
module tb_pio_ctrl;

`ifdef PIO_BLINK_EN
  localparam bit BlinkOn = 1'b1;
`else
  localparam bit BlinkOn = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        en;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] pdin;
  logic [31:0] pdout;
  logic        rd_valid;
  logic [7:0]  led;
  logic [31:0] gpio;

  pio_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .EN       (en),
    .WE       (we),
    .ADDR     (addr),
    .PData_in (pdin),
    .PData_out(pdout),
    .rd_valid (rd_valid),
    .LED      (led),
    .GPIOf0   (gpio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model state.
  bit [31:0] m_gpio, m_pout;
  bit [7:0]  m_blink;
  bit [23:0] m_period;
  int        m_cnt;
  bit        m_phase, m_rv;

  function automatic bit [7:0] model_led();
    bit [7:0] lit;
    lit = m_gpio[7:0] ^ (m_phase ? m_blink : 8'h00);
    return ~lit;
  endfunction

  task automatic check(input string name, input bit [31:0] got, input bit [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic model_step(input bit r, input bit e, input bit w, input bit [2:0] a,
                            input bit [31:0] d);
    if (r) begin
      m_gpio = 0; m_pout = 0; m_blink = 0; m_period = 0;
      m_cnt = 0; m_phase = 0; m_rv = 0;
      return;
    end
    m_rv = e && !w;
    if (m_rv) begin
      if (a <= 3) m_pout = m_gpio;
      else if (a == 4 && BlinkOn) m_pout = {24'h0, m_blink};
      else if (a == 5 && BlinkOn) m_pout = {8'h0, m_period};
      else m_pout = 0;
    end
    if (BlinkOn) begin
      if (e && w && a == 5) m_cnt = 0;
      else if (m_period == 0) begin m_cnt = 0; m_phase = 0; end
      else if (m_cnt == int'(m_period)) begin m_cnt = 0; m_phase = !m_phase; end
      else m_cnt = m_cnt + 1;
    end
    if (e && w) begin
      case (a)
        0: m_gpio = d;
        1: m_gpio = m_gpio | d;
        2: m_gpio = m_gpio & ~d;
        3: m_gpio = m_gpio ^ d;
        4: if (BlinkOn) m_blink = d[7:0];
        5: if (BlinkOn) m_period = d[23:0];
        default: ;
      endcase
    end
  endtask

  // Drive away from the falling edge, then let one falling edge happen.
  task automatic step(input bit r, input bit e, input bit w, input bit [2:0] a,
                      input bit [31:0] d);
    @(posedge clk);
    rst = r; en = e; we = w; addr = a; pdin = d;
    @(negedge clk);
    #1;
    model_step(r, e, w, a, d);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".gpio"}, gpio, m_gpio);
    check({tag, ".led"}, {24'h0, led}, {24'h0, model_led()});
    check({tag, ".pout"}, pdout, m_pout);
    check({tag, ".rv"}, {31'h0, rd_valid}, {31'h0, m_rv});
  endtask

  typedef struct {
    bit        r, e, w;
    bit [2:0]  a;
    bit [31:0] d;
    bit [31:0] x_gpio;
    bit [7:0]  x_led;
    bit [31:0] x_pout;
    bit        x_rv;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1; en = 1'b0; we = 1'b0; addr = 3'd0; pdin = 32'h0;

    //          r  e  w  a  data          gpio          led    pout          rv
    vecs.push_back('{1, 0, 0, 0, 32'h0,        32'h0,        8'hFF, 32'h0,        0});
    vecs.push_back('{0, 1, 1, 0, 32'h000000A5, 32'h000000A5, 8'h5A, 32'h0,        0});
    vecs.push_back('{0, 1, 0, 0, 32'h0,        32'h000000A5, 8'h5A, 32'h000000A5, 1});
    vecs.push_back('{0, 0, 0, 0, 32'h0,        32'h000000A5, 8'h5A, 32'h000000A5, 0});
    vecs.push_back('{0, 1, 1, 1, 32'h00000F00, 32'h00000FA5, 8'h5A, 32'h000000A5, 0});
    vecs.push_back('{0, 1, 1, 2, 32'h00000005, 32'h00000FA0, 8'h5F, 32'h000000A5, 0});
    vecs.push_back('{0, 1, 1, 3, 32'hFFFF0000, 32'hFFFF0FA0, 8'h5F, 32'h000000A5, 0});
    vecs.push_back('{0, 1, 1, 6, 32'h12345678, 32'hFFFF0FA0, 8'h5F, 32'h000000A5, 0});
    vecs.push_back('{0, 1, 0, 7, 32'h0,        32'hFFFF0FA0, 8'h5F, 32'h0,        1});
    vecs.push_back('{0, 1, 0, 3, 32'h0,        32'hFFFF0FA0, 8'h5F, 32'hFFFF0FA0, 1});
    vecs.push_back('{0, 0, 1, 0, 32'h0,        32'hFFFF0FA0, 8'h5F, 32'hFFFF0FA0, 0});
    vecs.push_back('{1, 1, 1, 0, 32'h00001234, 32'h0,        8'hFF, 32'h0,        0});
    vecs.push_back('{1, 1, 0, 0, 32'h0,        32'h0,        8'hFF, 32'h0,        0});

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].e, vecs[i].w, vecs[i].a, vecs[i].d);
      check($sformatf("vec%0d.gpio", i), gpio, vecs[i].x_gpio);
      check($sformatf("vec%0d.led", i), {24'h0, led}, {24'h0, vecs[i].x_led});
      check($sformatf("vec%0d.pout", i), pdout, vecs[i].x_pout);
      check($sformatf("vec%0d.rv", i), {31'h0, rd_valid}, {31'h0, vecs[i].x_rv});
    end

    // Blink sequence: BLINK=1, PERIOD=3, GPIOf0=0.
    step(0, 1, 1, 4, 32'h1);
    step(0, 1, 1, 5, 32'h3);
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 0, 0, 0);
      check($sformatf("blink.pre%0d", k), {24'h0, led}, 32'hFF);
    end
    step(0, 0, 0, 0, 0);
    check("blink.on", {24'h0, led}, BlinkOn ? 32'hFE : 32'hFF);
    for (int k = 1; k <= 3; k++) step(0, 0, 0, 0, 0);
    check("blink.hold", {24'h0, led}, BlinkOn ? 32'hFE : 32'hFF);
    step(0, 0, 0, 0, 0);
    check("blink.off", {24'h0, led}, 32'hFF);
    check("blink.gpio", gpio, 32'h0);
    for (int k = 1; k <= 4; k++) step(0, 0, 0, 0, 0);
    check("blink.on2", {24'h0, led}, BlinkOn ? 32'hFE : 32'hFF);
    // PERIOD=0 while phase=1: phase held on the write edge, then forced to 0.
    step(0, 1, 1, 5, 32'h0);
    check("halt.edge", {24'h0, led}, BlinkOn ? 32'hFE : 32'hFF);
    step(0, 1, 0, 5, 32'h0);
    check("halt.led", {24'h0, led}, 32'hFF);
    check("halt.rd5", pdout, 32'h0);
    check("halt.rv", {31'h0, rd_valid}, 32'h1);
    step(0, 1, 0, 4, 32'h0);
    check("rd4", pdout, BlinkOn ? 32'h1 : 32'h0);

    // Reset during active blink with all outputs set.
    step(0, 1, 1, 0, 32'hFFFFFFFF);
    step(0, 1, 1, 5, 32'h1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 32'h5A5A5A5A);
    check_model("rst");
    check("rst.led", {24'h0, led}, 32'hFF);
    check("rst.gpio", gpio, 32'h0);
    step(0, 1, 0, 5, 0);
    check("rst.period", pdout, 32'h0);

    // Randomized run against the model.
    for (int k = 0; k < 400; k++) begin
      bit        r, e, w;
      bit [2:0]  a;
      bit [31:0] d;
      r = ($urandom_range(0, 49) == 0);
      e = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1);
      a = 3'($urandom_range(0, 7));
      d = (a == 5) ? 32'($urandom_range(0, 5)) : $urandom;
      step(r, e, w, a, d);
      check_model($sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
